// File: rtl/fifo_reader_pkg.sv
// Shared state encoding and sizing helpers for the FIFO burst reader.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Idle counter must be able to hold TIMEOUT without wrapping.
  function automatic int idle_cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side signals plus the outgoing valid/ready/last stream.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  fifo_pull;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    input  fifo_dout, fifo_empty, fifo_count, m_ready,
    output fifo_pull, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_count, m_ready,
    input  fifo_pull, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// Single-entry registered stream stage: loads a word on demand, clears on accept.
module stream_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  last_in,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data_p1,
  output logic                  vld_p1,
  output logic                  last_p1
);

  // Stage p1: output register; data holds across accept so only valid/last clear.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load) begin
      data_p1 <= din;
      vld_p1  <= 1'b1;
      last_p1 <= last_in;
    end else if (vld_p1 && ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a first-word-fall-through FIFO in bursts of up to BURST_LEN beats,
// forcing a partial burst after TIMEOUT idle cycles with leftover data.
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                enable,
  output logic                busy,
  fifo_burst_reader_if.master bus
);

  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int IDLE_W = idle_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  BURST_BEATS = CNT_W'(BURST_LEN);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX    = '1;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    beats_left, beats_nxt;
  logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
  logic                load;
  logic [DATA_WIDTH-1:0] out_data;
  logic                out_vld;
  logic                out_last;

  // A slot is free when the output register is empty or being drained this cycle.
  assign load = (state == BURST) && (beats_left != '0) && !bus.fifo_empty &&
                (!out_vld || bus.m_ready);

  assign bus.fifo_pull = load;
  assign bus.m_data    = out_data;
  assign bus.m_valid   = out_vld;
  assign bus.m_last    = out_last;
  assign busy          = (state == BURST) || (state == FINISH);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= IDLE;
      beats_left <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_nxt;
      idle_cnt   <= idle_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beats_nxt = beats_left;
    idle_nxt  = idle_cnt;
    case (state)
      IDLE: begin
        if (enable && (bus.fifo_count >= BURST_BEATS)) begin
          state_nxt = BURST;
          beats_nxt = BURST_BEATS;
          idle_nxt  = '0;
        end else if (enable && (bus.fifo_count != '0) && (idle_cnt == IDLE_LAST)) begin
          state_nxt = BURST;
          beats_nxt = bus.fifo_count;
          idle_nxt  = '0;
        end else if (enable && (bus.fifo_count != '0)) begin
          idle_nxt = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
        end else begin
          idle_nxt = '0;
        end
      end
      BURST: begin
        if (load) begin
          beats_nxt = beats_left - 1'b1;
          if (beats_left == CNT_W'(1)) state_nxt = FINISH;
        end
      end
      FINISH: begin
        if (out_vld && bus.m_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  stream_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk     (clk),
    .res_n   (res_n),
    .load    (load),
    .din     (bus.fifo_dout),
    .last_in (beats_left == CNT_W'(1)),
    .ready   (bus.m_ready),
    .data_p1 (out_data),
    .vld_p1  (out_vld),
    .last_p1 (out_last)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader driving a behavioural FWFT FIFO of depth 8.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       res_n;
  logic       enable;
  logic       busy;
  logic       push;
  logic [7:0] push_data;
  logic       flush;

  logic [7:0] mem [8];
  logic [2:0] wr_ptr = '0;
  logic [2:0] rd_ptr = '0;
  logic [3:0] cnt = '0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] got_data [$];
  logic       got_last [$];
  int         viol = 0;
  int         hold_err = 0;
  int         pull_cnt = 0;
  int         busy_starts = 0;
  logic       prev_stall = 1'b0;
  logic       prev_busy = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  fifo_burst_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  fifo_burst_reader #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .BURST_LEN(4), .TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .res_n  (res_n),
    .enable (enable),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.fifo_dout  = mem[rd_ptr];
  assign bus.fifo_empty = (cnt == 4'd0);
  assign bus.fifo_count = cnt;

  always @(posedge clk) begin : fifo_model
    logic dpush, dpop;
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      dpop  = bus.fifo_pull && (cnt != 4'd0);
      dpush = push && ((cnt < 4'd8) || dpop);
      if (dpush) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 3'd1;
      end
      if (dpop) rd_ptr <= rd_ptr + 3'd1;
      cnt <= cnt + {3'd0, dpush} - {3'd0, dpop};
    end
  end

  // Stream monitor sampled mid-cycle, after the driver has settled its inputs.
  always @(negedge clk) begin
    #3;
    if (res_n) begin
      if (bus.m_valid && bus.m_ready) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
      end
      if (bus.fifo_pull) pull_cnt++;
      if (bus.fifo_pull && (bus.fifo_empty || (bus.m_valid && !bus.m_ready))) viol++;
      if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
        hold_err++;
      if (busy && !prev_busy) busy_starts++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      prev_busy  = busy;
    end else begin
      prev_stall = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      push      = 1'b1;
      push_data = 8'(first + i);
    end
    step();
    push = 1'b0;
  endtask

  task automatic wait_pull(output int n);
    n = 0;
    while (!bus.fifo_pull && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int k = 0;
    while (got_data.size() < target && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(got_data.size() >= target), 32'd1);
  endtask

  initial begin
    int n;
    int base;
    int pbase;
    int bbase;
    logic rpat [7];
    rpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    res_n = 1'b0; enable = 1'b1; bus.m_ready = 1'b1;
    push = 1'b0; push_data = '0; flush = 1'b0;

    // Reset held with data waiting in the FIFO.
    push_words(8'h50, 5);
    steps(2);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_last",  32'(bus.m_last),  32'd0);
    chk("rst_data",  32'(bus.m_data),  32'd0);
    chk("rst_pull",  32'(bus.fifo_pull), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_count", 32'(cnt), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    res_n = 1'b1;
    step();

    // Full burst with the sink always ready.
    push_words(8'h10, 4);
    wait_pull(n);
    chk("full_start", 32'(n), 32'd1);
    chk("full_v0", 32'(bus.m_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_pull", 32'(bus.fifo_pull), 32'd1);
      chk("full_data", 32'(bus.m_data), 32'(8'h10 + i));
      chk("full_last", 32'(bus.m_last), 32'd0);
    end
    step();
    chk("full_pull_end", 32'(bus.fifo_pull), 32'd0);
    chk("full_data3", 32'(bus.m_data), 32'h13);
    chk("full_last3", 32'(bus.m_last), 32'd1);
    step();
    chk("full_done_valid", 32'(bus.m_valid), 32'd0);
    chk("full_done_busy", 32'(busy), 32'd0);
    chk("full_done_count", 32'(cnt), 32'd0);
    steps(2);

    // Backpressure pattern during a burst.
    base = got_data.size();
    push_words(8'h20, 4);
    wait_pull(n);
    for (int i = 0; i < 7; i++) begin
      bus.m_ready = rpat[i];
      step();
    end
    bus.m_ready = 1'b1;
    wait_beats(base + 4, 50, "bp_done");
    steps(3);
    chk("bp_beats", 32'(got_data.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", 32'(got_data[base + i]), 32'(8'h20 + i));
      chk("bp_last", 32'(got_last[base + i]), 32'(i == 3));
    end

    // Partial burst forced by the idle timeout.
    base = got_data.size();
    push_words(8'hA0, 2);
    wait_pull(n);
    chk("to_start", 32'(n), 32'd15);
    wait_beats(base + 2, 20, "to_done");
    steps(3);
    chk("to_d0", 32'(got_data[base]), 32'hA0);
    chk("to_l0", 32'(got_last[base]), 32'd0);
    chk("to_d1", 32'(got_data[base + 1]), 32'hA1);
    chk("to_l1", 32'(got_last[base + 1]), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);

    // Full FIFO drained as two back-to-back bursts.
    enable = 1'b0;
    push_words(8'h00, 8);
    chk("ff_count8", 32'(cnt), 32'd8);
    base  = got_data.size();
    bbase = busy_starts;
    enable = 1'b1;
    wait_beats(base + 8, 60, "ff_done");
    steps(3);
    chk("ff_d3", 32'(got_data[base + 3]), 32'h03);
    chk("ff_l3", 32'(got_last[base + 3]), 32'd1);
    chk("ff_l2", 32'(got_last[base + 2]), 32'd0);
    chk("ff_d7", 32'(got_data[base + 7]), 32'h07);
    chk("ff_l7", 32'(got_last[base + 7]), 32'd1);
    chk("ff_bursts", 32'(busy_starts - bbase), 32'd2);
    chk("ff_count0", 32'(cnt), 32'd0);

    // Enable gating, then asynchronous reset in the middle of a burst.
    enable = 1'b0;
    push_words(8'h30, 8);
    pbase = pull_cnt;
    steps(40);
    chk("en_nopull", 32'(pull_cnt - pbase), 32'd0);
    enable = 1'b1;
    n = 0;
    while (cnt != 4'd6 && n < 20) begin
      step();
      n++;
    end
    chk("ar_reach", 32'(cnt), 32'd6);
    res_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.m_valid), 32'd0);
    chk("ar_pull",  32'(bus.fifo_pull), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    steps(3);
    chk("ar_count", 32'(cnt), 32'd6);
    res_n = 1'b1;
    base = got_data.size();
    wait_beats(base + 6, 100, "ar_done");
    steps(3);
    chk("ar_first", 32'(got_data[base]), 32'h32);
    chk("ar_l3", 32'(got_last[base + 3]), 32'd1);
    chk("ar_d5", 32'(got_data[base + 5]), 32'h37);
    chk("ar_l5", 32'(got_last[base + 5]), 32'd1);
    chk("ar_count0", 32'(cnt), 32'd0);

    chk("proto_viol", 32'(viol), 32'd0);
    chk("hold_err", 32'(hold_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
